dcf77_frame_sequencer: RTL and testbench

- Collects decoded DCF77 second-bits into a 59-bit frame, aligned to the minute marker.
- At each complete frame, snapshots it into a check buffer and drives the parity checker: start pulse in, pass/fail sampled after a fixed latency.
- Publishes validated frames and a lock status.
- Sits between the bit-slicer (pulse-width decoder) and the parity checker / time-decode registers.

---
 rtl/dcf77_frame_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_dcf77_frame_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcf77_frame_sequencer.sv
// dcf77_frame_sequencer
// Collects decoded DCF77 second-bits into a 59-bit frame aligned to the
// minute marker. Each complete frame goes into a check buffer and through
// the external parity checker. Frames that pass are published, and the
// block counts consecutive good frames to report lock.
module dcf77_frame_sequencer #(
   parameter int GAP_MAX = 100_000_000,
   parameter int CHK_LAT = 1,
   parameter int LOCK_N  = 3
)(
   input  logic        qzt_clk,
   input  logic        GSR,
   input  logic        bit_valid,
   input  logic        bit_value,
   input  logic        minute_mark,
   input  logic        chk_ok,
   output logic        chk_start,
   output logic [58:0] chk_buf,
   output logic [58:0] frame,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        lock,
   output logic [3:0]  good_cnt
);

   // Collector states
   localparam logic [0:0] COL_HUNT    = 1'b0;
   localparam logic [0:0] COL_COLLECT = 1'b1;

   // Checker handshake states
   localparam logic [1:0] CHK_IDLE  = 2'd0;
   localparam logic [1:0] CHK_START = 2'd1;
   localparam logic [1:0] CHK_WAIT  = 2'd2;

   localparam logic [26:0] GAP_LIMIT  = 27'(GAP_MAX);
   localparam logic [2:0]  LAT_LOAD   = 3'(CHK_LAT);
   localparam logic [3:0]  LOCK_LIMIT = 4'(LOCK_N);
   localparam logic [5:0]  FRAME_BITS = 6'd59;

   // Registered state
   logic [0:0]  col_state_r;
   logic [5:0]  idx_r;
   logic [26:0] gap_r;
   logic [58:0] collect_buf_r;
   logic [1:0]  chk_state_r;
   logic [2:0]  lat_r;
   logic        chk_start_r;
   logic [58:0] chk_buf_r;
   logic [58:0] frame_r;
   logic        frame_valid_r;
   logic        frame_err_r;
   logic [3:0]  good_cnt_r;

   // Next-state signals
   logic [0:0]  col_state_s;
   logic [5:0]  idx_s;
   logic [26:0] gap_s;
   logic [58:0] collect_buf_s;
   logic        chk_req_s;
   logic        col_err_s;
   logic [1:0]  chk_state_s;
   logic [2:0]  lat_s;
   logic        chk_start_s;
   logic        load_s;
   logic        pass_s;
   logic        fail_s;
   logic        drop_s;
   logic [58:0] chk_buf_s;
   logic [58:0] frame_s;
   logic        err_s;
   logic [3:0]  good_cnt_s;

   // Collector: follows minute marks, stores bits, and watches for gaps and overflow
   always_comb begin
      col_state_s   = col_state_r;
      idx_s         = idx_r;
      gap_s         = gap_r;
      collect_buf_s = collect_buf_r;
      chk_req_s     = 1'b0;
      col_err_s     = 1'b0;
      case (col_state_r)
         COL_HUNT: begin
            gap_s = 27'd0;
            if (minute_mark) begin
               col_state_s = COL_COLLECT;
               idx_s       = 6'd0;
            end else begin
               idx_s = idx_r;
            end
         end
         COL_COLLECT: begin
            if (minute_mark) begin
               // A mark takes priority over a coincident bit; that bit is dropped
               idx_s = 6'd0;
               gap_s = 27'd0;
               if (idx_r == FRAME_BITS) begin
                  chk_req_s = 1'b1;
               end else begin
                  col_err_s = 1'b1;
               end
            end else if (bit_valid) begin
               gap_s = 27'd0;
               if (idx_r == FRAME_BITS) begin
                  col_err_s   = 1'b1;
                  col_state_s = COL_HUNT;
                  idx_s       = 6'd0;
               end else begin
                  collect_buf_s[idx_r] = bit_value;
                  idx_s                = idx_r + 6'd1;
               end
            end else if (gap_r + 27'd1 == GAP_LIMIT) begin
               col_err_s   = 1'b1;
               col_state_s = COL_HUNT;
               idx_s       = 6'd0;
               gap_s       = 27'd0;
            end else begin
               gap_s = gap_r + 27'd1;
            end
         end
         default: begin
            col_state_s = COL_HUNT;
            idx_s       = 6'd0;
            gap_s       = 27'd0;
         end
      endcase
   end

   // Checker handshake: issues the start pulse, waits the latency, and samples the result
   always_comb begin
      chk_state_s = chk_state_r;
      lat_s       = lat_r;
      chk_start_s = 1'b0;
      load_s      = 1'b0;
      pass_s      = 1'b0;
      fail_s      = 1'b0;
      drop_s      = 1'b0;
      case (chk_state_r)
         CHK_IDLE: begin
            if (chk_req_s) begin
               chk_state_s = CHK_START;
               chk_start_s = 1'b1;
               load_s      = 1'b1;
            end else begin
               chk_state_s = CHK_IDLE;
            end
         end
         CHK_START: begin
            lat_s       = LAT_LOAD;
            chk_state_s = CHK_WAIT;
         end
         CHK_WAIT: begin
            if (lat_r <= 3'd1) begin
               lat_s       = 3'd0;
               chk_state_s = CHK_IDLE;
               if (chk_ok) begin
                  pass_s = 1'b1;
               end else begin
                  fail_s = 1'b1;
               end
            end else begin
               lat_s = lat_r - 3'd1;
            end
         end
         default: begin
            chk_state_s = CHK_IDLE;
            lat_s       = 3'd0;
         end
      endcase
      // A request while a check is in flight is discarded; chk_buf stays intact
      if (chk_req_s && (chk_state_r != CHK_IDLE)) begin
         drop_s = 1'b1;
      end else begin
         drop_s = 1'b0;
      end
   end

   // Output data path: check buffer copy, published frame, error merge and good counter
   always_comb begin
      chk_buf_s  = chk_buf_r;
      frame_s    = frame_r;
      good_cnt_s = good_cnt_r;
      if (load_s) begin
         chk_buf_s = collect_buf_r;
      end else begin
         chk_buf_s = chk_buf_r;
      end
      if (pass_s) begin
         frame_s = chk_buf_r;
      end else begin
         frame_s = frame_r;
      end
      err_s = col_err_s | fail_s | drop_s;
      if (err_s) begin
         good_cnt_s = 4'd0;
      end else if (pass_s) begin
         if (good_cnt_r >= LOCK_LIMIT) begin
            good_cnt_s = LOCK_LIMIT;
         end else begin
            good_cnt_s = good_cnt_r + 4'd1;
         end
      end else begin
         good_cnt_s = good_cnt_r;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge qzt_clk) begin
      if (GSR) begin
         col_state_r   <= COL_HUNT;
         idx_r         <= 6'd0;
         gap_r         <= 27'd0;
         collect_buf_r <= 59'd0;
         chk_state_r   <= CHK_IDLE;
         lat_r         <= 3'd0;
         chk_start_r   <= 1'b0;
         chk_buf_r     <= 59'd0;
         frame_r       <= 59'd0;
         frame_valid_r <= 1'b0;
         frame_err_r   <= 1'b0;
         good_cnt_r    <= 4'd0;
      end else begin
         col_state_r   <= col_state_s;
         idx_r         <= idx_s;
         gap_r         <= gap_s;
         collect_buf_r <= collect_buf_s;
         chk_state_r   <= chk_state_s;
         lat_r         <= lat_s;
         chk_start_r   <= chk_start_s;
         chk_buf_r     <= chk_buf_s;
         frame_r       <= frame_s;
         frame_valid_r <= pass_s;
         frame_err_r   <= err_s;
         good_cnt_r    <= good_cnt_s;
      end
   end

   assign chk_start   = chk_start_r;
   assign chk_buf     = chk_buf_r;
   assign frame       = frame_r;
   assign frame_valid = frame_valid_r;
   assign frame_err   = frame_err_r;
   assign good_cnt    = good_cnt_r;
   // lock is a pure decode of the good-frame counter
   assign lock        = (good_cnt_r == LOCK_LIMIT);

endmodule

// File: tb/tb_dcf77_frame_sequencer.sv
// Testbench for dcf77_frame_sequencer: directed scenarios plus randomized
// frames. Every cycle is compared against a frame-level reference model.
module tb_dcf77_frame_sequencer;

   localparam int GAP_MAX = 20;
   localparam int CHK_LAT = 1;
   localparam int LOCK_N  = 2;

   logic        qzt_clk = 1'b0;
   logic        GSR = 1'b1;
   logic        bit_valid = 1'b0;
   logic        bit_value = 1'b0;
   logic        minute_mark = 1'b0;
   logic        chk_ok = 1'b0;
   logic        chk_start;
   logic [58:0] chk_buf;
   logic [58:0] frame;
   logic        frame_valid;
   logic        frame_err;
   logic        lock;
   logic [3:0]  good_cnt;

   dcf77_frame_sequencer #(.GAP_MAX(GAP_MAX), .CHK_LAT(CHK_LAT), .LOCK_N(LOCK_N)) dut (
      .qzt_clk(qzt_clk), .GSR(GSR), .bit_valid(bit_valid), .bit_value(bit_value),
      .minute_mark(minute_mark), .chk_ok(chk_ok), .chk_start(chk_start),
      .chk_buf(chk_buf), .frame(frame), .frame_valid(frame_valid),
      .frame_err(frame_err), .lock(lock), .good_cnt(good_cnt)
   );

   always #5 qzt_clk = ~qzt_clk;

   int n_checks = 0;
   int n_errors = 0;
   int ok_mode  = 1;   // 0: random result, 1: checker passes, 2: checker fails

   // Reference model state (frame level)
   logic        q[$];
   logic        hunting = 1'b1;
   int          gap = 0;
   logic        pending = 1'b0;
   int          sample_edge = 0;
   int          edge_n = 0;
   logic [58:0] m_buf = '0;
   logic [58:0] m_frame = '0;
   int          m_good = 0;
   logic        e_start = 1'b0;
   logic        e_valid = 1'b0;
   logic        e_err = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
      end
   endtask

   // Reference model: one step per clock edge, using the inputs the DUT samples
   task automatic model_step();
      logic pass, cfail, colerr, req, drop, busy;
      logic [58:0] snap;
      pass = 1'b0; cfail = 1'b0; colerr = 1'b0; req = 1'b0; drop = 1'b0;
      snap = '0;
      edge_n++;
      e_start = 1'b0; e_valid = 1'b0; e_err = 1'b0;
      if (GSR) begin
         hunting = 1'b1; q.delete(); gap = 0; pending = 1'b0;
         m_buf = '0; m_frame = '0; m_good = 0;
         return;
      end
      busy = pending;
      if (pending && edge_n == sample_edge) begin
         pending = 1'b0;
         if (chk_ok) pass = 1'b1;
         else cfail = 1'b1;
      end
      if (hunting) begin
         if (minute_mark) begin
            hunting = 1'b0; q.delete(); gap = 0;
         end
      end else if (minute_mark) begin
         if (q.size() == 59) begin
            req = 1'b1;
            for (int i = 0; i < 59; i++) snap[i] = q[i];
         end else begin
            colerr = 1'b1;
         end
         q.delete(); gap = 0;
      end else if (bit_valid) begin
         gap = 0;
         if (q.size() == 59) begin
            colerr = 1'b1; hunting = 1'b1; q.delete();
         end else begin
            q.push_back(bit_value);
         end
      end else begin
         gap++;
         if (gap == GAP_MAX) begin
            colerr = 1'b1; hunting = 1'b1; gap = 0; q.delete();
         end
      end
      if (pass) m_frame = m_buf;
      if (req) begin
         if (busy) begin
            drop = 1'b1;
         end else begin
            pending = 1'b1; sample_edge = edge_n + 1 + CHK_LAT;
            m_buf = snap; e_start = 1'b1;
         end
      end
      e_valid = pass;
      e_err = colerr | cfail | drop;
      if (e_err) m_good = 0;
      else if (pass) m_good = (m_good + 1 > LOCK_N) ? LOCK_N : m_good + 1;
   endtask

   // One clock cycle: drive on falling edge, model on rising edge, compare just after
   task automatic cyc(input logic bv, input logic bval, input logic mm, input logic gsr);
      @(negedge qzt_clk);
      GSR = gsr; bit_valid = bv; bit_value = bval; minute_mark = mm;
      if (ok_mode == 1) chk_ok = 1'b1;
      else if (ok_mode == 2) chk_ok = 1'b0;
      else chk_ok = ($urandom_range(0, 5) != 0);
      @(posedge qzt_clk);
      model_step();
      #1;
      check_val("chk_start", 64'(chk_start), 64'(e_start));
      check_val("frame_valid", 64'(frame_valid), 64'(e_valid));
      check_val("frame_err", 64'(frame_err), 64'(e_err));
      check_val("good_cnt", 64'(good_cnt), 64'(m_good));
      check_val("lock", 64'(lock), 64'(m_good == LOCK_N));
      check_val("frame", 64'(frame), 64'(m_frame));
      check_val("chk_buf", 64'(chk_buf), 64'(m_buf));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mark();
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Send n random bits with short random gaps (always below GAP_MAX)
   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(0, 3));
         cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      // Good frames until lock, plus one more to show saturation
      ok_mode = 1;
      send_bits(5);                 // ignored while hunting
      mark();
      for (int f = 0; f < 3; f++) begin
         send_bits(59);
         mark();
      end
      idle(4);
      // Checker reports a failure
      ok_mode = 2;
      send_bits(59);
      mark();
      idle(4);
      // Short frame, then a normal one
      ok_mode = 1;
      send_bits(40);
      mark();
      send_bits(59);
      mark();
      idle(4);
      // Overflow on the 60th bit, bits ignored until the next mark
      send_bits(60);
      send_bits(6);
      mark();
      send_bits(59);
      mark();
      idle(4);
      // Gap timeout mid-frame
      send_bits(10);
      idle(GAP_MAX);
      send_bits(4);
      mark();
      send_bits(59);
      mark();
      idle(4);
      // Bit and mark coincide: only the mark counts
      send_bits(59);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      send_bits(59);
      mark();
      idle(4);
      // Reset while the check is waiting for its result
      send_bits(59);
      mark();
      idle(1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      send_bits(5);
      mark();
      send_bits(59);
      mark();
      idle(4);
      // Randomized frames with random checker results
      ok_mode = 0;
      for (int f = 0; f < 14; f++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 6) send_bits(59);
         else if (sel == 6) send_bits(58);
         else if (sel == 7) send_bits(60);
         else if (sel == 8) begin send_bits(20); idle(GAP_MAX); end
         else send_bits(30);
         if ($urandom_range(0, 7) == 0) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
         else mark();
         idle($urandom_range(0, 3));
      end
      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
